// File: rtl/fan_pkg.sv
// Shared fan speed encoding used by the fan controller and by BatteryManager benches.
package fan_pkg;

    localparam logic [1:0] ST_OFF  = 2'b00;
    localparam logic [1:0] ST_LOW  = 2'b01;
    localparam logic [1:0] ST_MID  = 2'b10;
    localparam logic [1:0] ST_HIGH = 2'b11;

    localparam int DEF_LOW_BATT_PCT  = 20;
    localparam int DEF_LOW_BATT_HYST = 5;
    localparam int DEF_TIMER_STEP_S  = 30;
    localparam int DEF_TIMER_MAX_S   = 90;
    localparam int DEF_PWM_PERIOD    = 100;
    localparam int DEF_DUTY_LOW      = 30;
    localparam int DEF_DUTY_MID      = 60;
    localparam int DEF_DUTY_HIGH     = 100;

    typedef enum logic [1:0] {
        SPD_OFF  = ST_OFF,
        SPD_LOW  = ST_LOW,
        SPD_MID  = ST_MID,
        SPD_HIGH = ST_HIGH
    } speed_e;

    // Speed key sequence; with a low battery MID folds back to LOW instead of reaching HIGH.
    function automatic speed_e speed_step(input speed_e cur, input logic low);
        speed_e nxt;
        case (cur)
            SPD_OFF: nxt = SPD_LOW;
            SPD_LOW: nxt = SPD_MID;
            SPD_MID: nxt = low ? SPD_LOW : SPD_HIGH;
            default: nxt = SPD_LOW;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/fan_pwm_gen.sv
// Free-running PWM generator; duty changes are latched at period start, except that
// a zero duty stops the output on the very next edge.
module fan_pwm_gen #(
    parameter int PERIOD = 100,
    parameter int DUTY_W = $clog2(PERIOD + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DUTY_W-1:0] duty,
    output logic              fan_pwm
);

    localparam int CNT_W = (PERIOD > 1) ? $clog2(PERIOD) : 1;

    logic [CNT_W-1:0]  cnt_reg, cnt_next;
    logic [DUTY_W-1:0] duty_reg, duty_next;
    logic              pwm_reg, pwm_next;

    always_comb begin
        cnt_next  = (cnt_reg == CNT_W'(PERIOD - 1)) ? '0 : cnt_reg + 1'b1;
        duty_next = duty_reg;
        if (duty == '0) begin
            duty_next = '0;
        end else if (cnt_next == '0) begin
            duty_next = duty;
        end
        pwm_next = (DUTY_W'(cnt_next) < duty_next);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg  <= '0;
            duty_reg <= '0;
            pwm_reg  <= 1'b0;
        end else begin
            cnt_reg  <= cnt_next;
            duty_reg <= duty_next;
            pwm_reg  <= pwm_next;
        end
    end

    assign fan_pwm = pwm_reg;

endmodule

// File: rtl/fan_mode_controller.sv
// Fan speed sequencer with auto-off countdown, battery policy and PWM motor drive.
module fan_mode_controller
    import fan_pkg::*;
#(
    parameter int LOW_BATT_PCT  = DEF_LOW_BATT_PCT,
    parameter int LOW_BATT_HYST = DEF_LOW_BATT_HYST,
    parameter int TIMER_STEP_S  = DEF_TIMER_STEP_S,
    parameter int TIMER_MAX_S   = DEF_TIMER_MAX_S,
    parameter int PWM_PERIOD    = DEF_PWM_PERIOD,
    parameter int DUTY_LOW      = DEF_DUTY_LOW,
    parameter int DUTY_MID      = DEF_DUTY_MID,
    parameter int DUTY_HIGH     = DEF_DUTY_HIGH
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       key_speed,
    input  logic       key_off,
    input  logic       key_timer,
    input  logic       timer_1s,
    input  logic [7:0] battery,
    input  logic       battery_empty,
    output logic [1:0] state,
    output logic [6:0] countdown,
    output logic       low_batt,
    output logic       fan_pwm
);

    localparam int DUTY_W = $clog2(PWM_PERIOD + 1);

    speed_e            state_reg, state_next;
    logic [6:0]        countdown_reg, countdown_next;
    logic [6:0]        cd_dec, cd_ext;
    logic [7:0]        cd_sum, batt_clamped;
    logic              low_batt_reg, low_batt_next;
    logic              expire;
    logic [DUTY_W-1:0] duty;

    always_comb begin
        batt_clamped  = (battery > 8'd99) ? 8'd99 : battery;
        low_batt_next = low_batt_reg;
        if (batt_clamped < 8'(LOW_BATT_PCT)) begin
            low_batt_next = 1'b1;
        end else if (batt_clamped >= 8'(LOW_BATT_PCT + LOW_BATT_HYST)) begin
            low_batt_next = 1'b0;
        end
    end

    // Timer extension is applied on top of the (possibly) decremented count.
    always_comb begin
        expire = timer_1s && (countdown_reg == 7'd1);
        cd_dec = (timer_1s && (countdown_reg > 7'd1)) ? countdown_reg - 7'd1 : countdown_reg;
        cd_sum = {1'b0, cd_dec} + 8'(TIMER_STEP_S);
        if (cd_dec == 7'(TIMER_MAX_S)) begin
            cd_ext = '0;
        end else if (cd_sum > 8'(TIMER_MAX_S)) begin
            cd_ext = 7'(TIMER_MAX_S);
        end else begin
            cd_ext = cd_sum[6:0];
        end
    end

    always_comb begin
        state_next     = state_reg;
        countdown_next = cd_dec;
        if (battery_empty || key_off || expire) begin
            state_next     = SPD_OFF;
            countdown_next = '0;
        end else begin
            // The HIGH cap takes the place of a speed key in the same cycle.
            if ((state_reg == SPD_HIGH) && low_batt_reg) begin
                state_next = SPD_MID;
            end else if (key_speed) begin
                state_next = speed_step(state_reg, low_batt_reg);
            end
            if (key_timer && !key_speed && (state_reg != SPD_OFF)) begin
                countdown_next = cd_ext;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= SPD_OFF;
            countdown_reg <= '0;
            low_batt_reg  <= 1'b0;
        end else begin
            state_reg     <= state_next;
            countdown_reg <= countdown_next;
            low_batt_reg  <= low_batt_next;
        end
    end

    // Duty follows the next state so that OFF reaches the motor on the same edge.
    always_comb begin
        duty = '0;
        case (state_next)
            SPD_LOW:  duty = DUTY_W'(DUTY_LOW);
            SPD_MID:  duty = DUTY_W'(DUTY_MID);
            SPD_HIGH: duty = DUTY_W'(DUTY_HIGH);
            default:  duty = '0;
        endcase
    end

    fan_pwm_gen #(
        .PERIOD (PWM_PERIOD),
        .DUTY_W (DUTY_W)
    ) u_pwm (
        .clk     (clk),
        .rst_n   (rst_n),
        .duty    (duty),
        .fan_pwm (fan_pwm)
    );

    assign state     = state_reg;
    assign countdown = countdown_reg;
    assign low_batt  = low_batt_reg;

endmodule

// File: tb/tb_fan_mode_controller.sv
// Directed scenarios plus randomized traffic against a behavioural model of the fan controller.
module tb_fan_mode_controller;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       key_speed = 1'b0;
    logic       key_off = 1'b0;
    logic       key_timer = 1'b0;
    logic       timer_1s = 1'b0;
    logic [7:0] battery = 8'd50;
    logic       battery_empty = 1'b0;
    logic [1:0] state;
    logic [6:0] countdown;
    logic       low_batt;
    logic       fan_pwm;

    int errors = 0;
    int checks = 0;

    // Behavioural model: speed 0..3, countdown seconds, flag, edges since reset, period duty.
    int m_state = 0;
    int m_cd    = 0;
    int m_low   = 0;
    int m_n     = 0;
    int m_duty  = 0;
    int m_pwm   = 0;

    always #5 clk = ~clk;

    fan_mode_controller dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .key_speed     (key_speed),
        .key_off       (key_off),
        .key_timer     (key_timer),
        .timer_1s      (timer_1s),
        .battery       (battery),
        .battery_empty (battery_empty),
        .state         (state),
        .countdown     (countdown),
        .low_batt      (low_batt),
        .fan_pwm       (fan_pwm)
    );

    function automatic int duty_for(input int s);
        case (s)
            1: return 30;
            2: return 60;
            3: return 100;
            default: return 0;
        endcase
    endfunction

    task automatic model_reset();
        m_state = 0; m_cd = 0; m_low = 0; m_n = 0; m_duty = 0; m_pwm = 0;
    endtask

    // One clock: drive pulses, advance the model at the edge, return 1 time unit after it.
    task automatic cycle(input bit ks, input bit ko, input bit kt, input bit t1);
        int b, nlow, ns, ncd, base, pos;
        key_speed = ks; key_off = ko; key_timer = kt; timer_1s = t1;
        @(posedge clk);
        b = (int'(battery) > 99) ? 99 : int'(battery);
        nlow = (b < 20) ? 1 : ((b >= 25) ? 0 : m_low);
        ns = m_state;
        ncd = m_cd;
        if (battery_empty || ko || (t1 && m_cd == 1)) begin
            ns = 0;
            ncd = 0;
        end else begin
            if (m_state == 3 && m_low == 1) ns = 2;
            else if (ks) begin
                if (m_state == 0) ns = 1;
                else if (m_state == 1) ns = 2;
                else if (m_state == 2) ns = (m_low == 1) ? 1 : 3;
                else ns = 1;
            end
            base = (t1 && m_cd > 1) ? m_cd - 1 : m_cd;
            ncd = base;
            if (kt && !ks && m_state != 0) begin
                if (base == 90) ncd = 0;
                else ncd = (base + 30 > 90) ? 90 : base + 30;
            end
        end
        m_n++;
        pos = m_n % 100;
        if (pos == 0) m_duty = duty_for(ns);
        if (ns == 0) m_duty = 0;
        m_pwm = (pos < m_duty) ? 1 : 0;
        m_state = ns; m_cd = ncd; m_low = nlow;
        #1;
        key_speed = 1'b0; key_off = 1'b0; key_timer = 1'b0; timer_1s = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (state !== 2'b00 || countdown !== 7'd0 || low_batt !== 1'b0 || fan_pwm !== 1'b0) begin
            errors++;
            $display("FAIL reset: state=%0d countdown=%0d low_batt=%0b fan_pwm=%0b, required 0/0/0/0",
                     state, countdown, low_batt, fan_pwm);
        end
        @(negedge clk);
        rst_n = 1'b1;
        $display("reset released");
    endtask

    task automatic test_speed_pwm();
        int exp_state [4] = '{1, 2, 3, 1};
        int cnt, g;
        battery = 8'd50;
        for (int i = 0; i < 4; i++) begin
            cycle(1, 0, 0, 0);
            checks++;
            if (state !== 2'(exp_state[i])) begin
                errors++;
                $display("FAIL speed_step%0d: state=%0d required %0d", i, state, exp_state[i]);
            end
            $display("speed press %0d -> state=%0d", i, state);
            if (i < 3) begin
                g = 0;
                while ((m_n % 100) != 0 && g < 200) begin
                    cycle(0, 0, 0, 0);
                    g++;
                end
                cnt = 0;
                for (int k = 0; k < 100; k++) begin
                    if (fan_pwm === 1'b1) cnt++;
                    cycle(0, 0, 0, 0);
                end
                checks++;
                if (cnt != duty_for(exp_state[i])) begin
                    errors++;
                    $display("FAIL pwm_duty_speed%0d: high cycles=%0d required %0d", exp_state[i], cnt,
                             duty_for(exp_state[i]));
                end
                $display("pwm window speed=%0d high=%0d", exp_state[i], cnt);
            end
        end
    endtask

    task automatic test_timer();
        int exp_cd [6] = '{30, 60, 90, 0, 30, 60};
        int ec, es;
        for (int i = 0; i < 6; i++) begin
            cycle(0, 0, 1, 0);
            checks++;
            if (countdown !== 7'(exp_cd[i])) begin
                errors++;
                $display("FAIL timer_press%0d: countdown=%0d required %0d", i, countdown, exp_cd[i]);
            end
            $display("timer press %0d -> countdown=%0d", i, countdown);
        end
        for (int i = 1; i <= 60; i++) begin
            cycle(0, 0, 0, 1);
            ec = (i < 60) ? 60 - i : 0;
            es = (i < 60) ? 1 : 0;
            checks++;
            if (countdown !== 7'(ec) || state !== 2'(es)) begin
                errors++;
                $display("FAIL tick%0d: countdown=%0d state=%0d required %0d/%0d", i, countdown, state, ec, es);
            end
            cycle(0, 0, 0, 0);
        end
        $display("auto-off expiry: state=%0d countdown=%0d", state, countdown);
    endtask

    task automatic test_low_batt();
        int exp_ks [3] = '{1, 2, 1};
        battery = 8'd25;
        repeat (3) cycle(1, 0, 0, 0);
        checks++;
        if (state !== 2'b11) begin
            errors++;
            $display("FAIL lb_reach_high: state=%0d required 3", state);
        end
        battery = 8'd19;
        cycle(0, 0, 0, 0);
        checks++;
        if (low_batt !== 1'b1 || state !== 2'b11) begin
            errors++;
            $display("FAIL lb_set: low_batt=%0b state=%0d required 1/3", low_batt, state);
        end
        cycle(0, 0, 0, 0);
        checks++;
        if (state !== 2'b10) begin
            errors++;
            $display("FAIL lb_cap: state=%0d required 2", state);
        end
        for (int i = 0; i < 3; i++) begin
            cycle(1, 0, 0, 0);
            checks++;
            if (state !== 2'(exp_ks[i])) begin
                errors++;
                $display("FAIL lb_speed%0d: state=%0d required %0d", i, state, exp_ks[i]);
            end
        end
        battery = 8'd24;
        cycle(0, 0, 0, 0);
        checks++;
        if (low_batt !== 1'b1) begin
            errors++;
            $display("FAIL lb_hold24: low_batt=%0b required 1", low_batt);
        end
        battery = 8'd25;
        cycle(0, 0, 0, 0);
        checks++;
        if (low_batt !== 1'b0) begin
            errors++;
            $display("FAIL lb_clear25: low_batt=%0b required 0", low_batt);
        end
        $display("low battery scenario done: state=%0d low_batt=%0b", state, low_batt);
    endtask

    task automatic test_empty();
        battery = 8'd50;
        cycle(0, 1, 0, 0);
        cycle(1, 0, 0, 0);
        cycle(1, 0, 0, 0);
        cycle(0, 0, 1, 0);
        cycle(0, 0, 1, 0);
        checks++;
        if (state !== 2'b10 || countdown !== 7'd60) begin
            errors++;
            $display("FAIL empty_setup: state=%0d countdown=%0d required 2/60", state, countdown);
        end
        battery_empty = 1'b1;
        cycle(1, 1, 0, 0);
        checks++;
        if (state !== 2'b00 || countdown !== 7'd0) begin
            errors++;
            $display("FAIL empty_force_off: state=%0d countdown=%0d required 0/0", state, countdown);
        end
        cycle(1, 0, 0, 0);
        cycle(0, 0, 1, 0);
        checks++;
        if (state !== 2'b00 || countdown !== 7'd0) begin
            errors++;
            $display("FAIL empty_keys_ignored: state=%0d countdown=%0d required 0/0", state, countdown);
        end
        battery_empty = 1'b0;
        $display("battery empty scenario done: state=%0d", state);
    endtask

    task automatic test_same_cycle();
        cycle(1, 0, 0, 0);
        cycle(0, 0, 1, 0);
        for (int i = 0; i < 29; i++) begin
            cycle(0, 0, 0, 1);
            cycle(0, 0, 0, 0);
        end
        checks++;
        if (countdown !== 7'd1) begin
            errors++;
            $display("FAIL same_setup1: countdown=%0d required 1", countdown);
        end
        cycle(1, 0, 0, 1);
        checks++;
        if (state !== 2'b00 || countdown !== 7'd0) begin
            errors++;
            $display("FAIL expiry_beats_speed: state=%0d countdown=%0d required 0/0", state, countdown);
        end
        cycle(1, 0, 0, 0);
        cycle(0, 0, 1, 0);
        cycle(0, 0, 1, 0);
        for (int i = 0; i < 20; i++) begin
            cycle(0, 0, 0, 1);
            cycle(0, 0, 0, 0);
        end
        checks++;
        if (countdown !== 7'd40) begin
            errors++;
            $display("FAIL same_setup40: countdown=%0d required 40", countdown);
        end
        cycle(0, 0, 1, 1);
        checks++;
        if (countdown !== 7'd69) begin
            errors++;
            $display("FAIL tick_plus_timer: countdown=%0d required 69", countdown);
        end
        $display("same-cycle scenario done: countdown=%0d", countdown);
    endtask

    task automatic test_random();
        int bad;
        bit ks, kt, ko, t1;
        bad = 0;
        for (int i = 0; i < 3000; i++) begin
            ks = ($urandom_range(0, 9) == 0);
            kt = !ks && ($urandom_range(0, 6) == 0);
            ko = ($urandom_range(0, 79) == 0);
            t1 = ($urandom_range(0, 4) == 0);
            if ($urandom_range(0, 24) == 0) begin
                if ($urandom_range(0, 9) == 0) battery = 8'($urandom_range(100, 255));
                else if ($urandom_range(0, 1) == 0) battery = 8'($urandom_range(15, 30));
                else battery = 8'($urandom_range(0, 99));
            end
            battery_empty = ($urandom_range(0, 199) == 0);
            cycle(ks, ko, kt, t1);
            checks++;
            if (state !== 2'(m_state) || countdown !== 7'(m_cd) || low_batt !== 1'(m_low)
                || fan_pwm !== 1'(m_pwm)) begin
                errors++;
                bad++;
                $display("FAIL random_cycle%0d: state=%0d cd=%0d low=%0b pwm=%0b required %0d/%0d/%0d/%0d",
                         i, state, countdown, low_batt, fan_pwm, m_state, m_cd, m_low, m_pwm);
            end
        end
        battery_empty = 1'b0;
        $display("random traffic: 3000 cycles, %0d mismatching", bad);
    endtask

    task automatic test_async_reset();
        int g;
        battery = 8'd50;
        cycle(0, 1, 0, 0);
        repeat (3) cycle(1, 0, 0, 0);
        cycle(0, 0, 1, 0);
        cycle(0, 0, 1, 0);
        for (int i = 0; i < 10; i++) begin
            cycle(0, 0, 0, 1);
            cycle(0, 0, 0, 0);
        end
        checks++;
        if (state !== 2'b11 || countdown !== 7'd50) begin
            errors++;
            $display("FAIL arst_setup: state=%0d countdown=%0d required 3/50", state, countdown);
        end
        g = 0;
        while (fan_pwm !== 1'b1 && g < 250) begin
            cycle(0, 0, 0, 0);
            g++;
        end
        checks++;
        if (fan_pwm !== 1'b1) begin
            errors++;
            $display("FAIL arst_pwm_high_wait: fan_pwm=%0b required 1 within 250 cycles", fan_pwm);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (fan_pwm !== 1'b0 || state !== 2'b00 || countdown !== 7'd0) begin
            errors++;
            $display("FAIL arst_immediate: fan_pwm=%0b state=%0d countdown=%0d required 0/0/0",
                     fan_pwm, state, countdown);
        end
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        $display("async reset mid-period: fan_pwm=%0b state=%0d", fan_pwm, state);
    endtask

    initial begin
        test_reset();
        test_speed_pwm();
        test_timer();
        test_low_batt();
        test_empty();
        test_same_cycle();
        test_random();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
